execute_pipe_mc: RTL and testbench

- Parametrised successor to the single-cycle execute stage.
- Sits between decode/register-read and memory stage; registers its own outputs.
- Adds a valid/ready handshake on both sides, an iterative multi-cycle multiplier, flush support and sign-extended branch/jump offsets.
- ALU ops complete in 1 cycle. Multiplies take XLEN/MUL_BPC cycles and stall upstream.

---
 rtl/execute_pipe_mc_pkg.sv | 36 +++
 rtl/execute_pipe_mc_alu.sv | 41 ++++
 rtl/execute_pipe_mc_mul_iter.sv | 69 ++++++
 rtl/execute_pipe_mc.sv | 159 +++++++++++++++
 tb/tb_execute_pipe_mc.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_pipe_mc_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU op selects,
// ctrl_in bit positions and FSM state codes.
package execute_pipe_mc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam int CTRL_W        = 12;
  localparam int CTRL_PCTOREG  = 11;
  localparam int CTRL_REGTOPC  = 10;
  localparam int CTRL_JUMP     = 9;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_BZERO    = 7;
  localparam int CTRL_RTYPE    = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_LOADSIGN = 2;
  localparam int CTRL_MUL      = 1;
  localparam int CTRL_SPARE    = 0;

endpackage

// File: rtl/execute_pipe_mc_alu.sv
// Single-cycle combinational ALU shared with the original execute stage.
module alu
  import execute_pipe_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);

  localparam int SHW = $clog2(XLEN);

  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic [SHW-1:0]         w_shamt;

  assign w_a_s   = i_a;
  assign w_b_s   = i_b;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_NOR:  o_y = ~(i_a | i_b);
      ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
      ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = $unsigned(w_a_s >>> w_shamt);
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/execute_pipe_mc_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle;
// only the low XLEN product bits are kept.
module mul_iter #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int STEPS = XLEN / MUL_BPC;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_partial;
  logic [XLEN-1:0] w_acc_next;

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  // The final step's sum is presented directly so the caller can capture it
  // on the same edge that the counter reaches zero.
  assign w_acc_next = r_acc + w_partial;
  assign o_product  = w_acc_next;
  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset || i_kill) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_LAST;
    end else if (r_busy) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << MUL_BPC;
      r_mplier <= r_mplier >> MUL_BPC;
    end
  end

endmodule

// File: rtl/execute_pipe_mc.sv
// Execute stage with valid/ready on both sides, 1-cycle ALU ops, iterative
// multiply that stalls upstream, flush, and branch/jump target resolution.
module execute_pipe_mc
  import execute_pipe_mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BPC  = 1,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic [XLEN-1:0]     nextPC_in,
  input  logic [XLEN-1:0]     opA_in,
  input  logic [XLEN-1:0]     opB_in,
  input  logic [25:0]         offset26_in,
  input  logic [15:0]         offset16_in,
  input  logic [REG_BITS-1:0] destReg_in,
  input  logic [3:0]          ALUCtrl_in,
  input  logic [CTRL_W-1:0]   ctrl_in,
  input  logic [1:0]          DSize_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     nextPC_out,
  output logic [XLEN-1:0]     aluResult_out,
  output logic [XLEN-1:0]     leapAddr_out,
  output logic [REG_BITS-1:0] destReg_out,
  output logic                leap_out,
  output logic                PCtoReg_out,
  output logic                RegWrite_out,
  output logic                MemToReg_out,
  output logic                MemWrite_out,
  output logic                loadSign_out,
  output logic [1:0]          DSize_out
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_is_mul;
  logic                   w_mul_start;
  logic                   w_mul_busy;
  logic                   w_mul_done;
  logic [XLEN-1:0]        w_mul_p;
  logic [XLEN-1:0]        w_alu_y;
  logic [XLEN-1:0]        w_leap_addr;
  logic                   w_leap;
  logic signed [XLEN-1:0] w_off16_sx;
  logic signed [XLEN-1:0] w_off26_sx;
  logic [1:0]             w_unused_ctrl;

  assign w_unused_ctrl = {ctrl_in[CTRL_RTYPE], ctrl_in[CTRL_SPARE]};
  assign w_is_mul      = ctrl_in[CTRL_MUL];
  assign w_accept      = in_valid && in_ready && !flush;
  assign w_mul_start   = w_accept && w_is_mul;
  assign in_ready      = w_in_ready;

  alu #(.XLEN(XLEN)) u_alu (
    .i_op (ALUCtrl_in),
    .i_a  (opA_in),
    .i_b  (opB_in),
    .o_y  (w_alu_y)
  );

  mul_iter #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mul_start),
    .i_kill    (flush),
    .i_a       (opA_in),
    .i_b       (opB_in),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_p)
  );

  assign w_off16_sx = XLEN'(signed'(offset16_in));
  assign w_off26_sx = XLEN'(signed'(offset26_in));

  always_comb begin
    w_leap_addr = nextPC_in;
    if (ctrl_in[CTRL_REGTOPC])     w_leap_addr = opA_in;
    else if (ctrl_in[CTRL_BRANCH]) w_leap_addr = nextPC_in + $unsigned(w_off16_sx);
    else if (ctrl_in[CTRL_JUMP])   w_leap_addr = nextPC_in + $unsigned(w_off26_sx);
  end

  always_comb begin
    w_leap = 1'b0;
    if (w_is_mul)                  w_leap = 1'b0;
    else if (ctrl_in[CTRL_JUMP])   w_leap = 1'b1;
    else if (ctrl_in[CTRL_BRANCH]) w_leap = ctrl_in[CTRL_BZERO] ? (opA_in == '0)
                                                                : (opA_in != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (w_mul_start) w_state_next = MUL_BUSY;
        MUL_BUSY: if (w_mul_done)  w_state_next = IDLE;
        default:  w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready = !reset && (r_state == IDLE) && !w_mul_busy && (!out_valid || out_ready);
  end

  // Output register: a mul loads its pass-through fields at accept and
  // fills in the product when the multiplier finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      nextPC_out    <= '0;
      aluResult_out <= '0;
      leapAddr_out  <= '0;
      destReg_out   <= '0;
      leap_out      <= 1'b0;
      PCtoReg_out   <= 1'b0;
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      MemWrite_out  <= 1'b0;
      loadSign_out  <= 1'b0;
      DSize_out     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid     <= !w_is_mul;
      nextPC_out    <= nextPC_in;
      aluResult_out <= w_alu_y;
      leapAddr_out  <= w_leap_addr;
      destReg_out   <= destReg_in;
      leap_out      <= w_leap;
      PCtoReg_out   <= ctrl_in[CTRL_PCTOREG];
      RegWrite_out  <= ctrl_in[CTRL_REGWRITE];
      MemToReg_out  <= ctrl_in[CTRL_MEMTOREG];
      MemWrite_out  <= ctrl_in[CTRL_MEMWRITE];
      loadSign_out  <= ctrl_in[CTRL_LOADSIGN];
      DSize_out     <= DSize_in;
    end else if (w_mul_done) begin
      out_valid     <= 1'b1;
      aluResult_out <= w_mul_p;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_pipe_mc.sv
// Scoreboard bench for execute_pipe_mc: ALU, multiply, branch/jump,
// backpressure, flush and reset-during-multiply scenarios.
module tb_execute_pipe_mc;

  localparam int XLEN     = 32;
  localparam int MUL_BPC  = 1;
  localparam int REG_BITS = 5;
  localparam int MUL_CYC  = XLEN / MUL_BPC;

  localparam logic [11:0] C_PCTOREG  = 12'h800;
  localparam logic [11:0] C_REGTOPC  = 12'h400;
  localparam logic [11:0] C_JUMP     = 12'h200;
  localparam logic [11:0] C_BRANCH   = 12'h100;
  localparam logic [11:0] C_BZ       = 12'h080;
  localparam logic [11:0] C_RTYPE    = 12'h040;
  localparam logic [11:0] C_REGWRITE = 12'h020;
  localparam logic [11:0] C_MEMTOREG = 12'h010;
  localparam logic [11:0] C_MEMWRITE = 12'h008;
  localparam logic [11:0] C_LOADSIGN = 12'h004;
  localparam logic [11:0] C_MUL      = 12'h002;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7,
                         OP_SLL = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] npc;
    logic [15:0] o16;
    logic [25:0] o26;
    logic [11:0] ctrl;
    logic [4:0]  dest;
    logic [1:0]  dsize;
  } op_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] res;
    logic [31:0] laddr;
    logic [4:0]  dest;
    logic        leap;
    logic        pctoreg;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        loadsign;
    logic [1:0]  dsize;
  } out_t;

  logic                clk = 1'b0;
  logic                reset, in_valid, flush, out_ready;
  logic                in_ready, out_valid;
  logic [XLEN-1:0]     nextPC_in, opA_in, opB_in;
  logic [25:0]         offset26_in;
  logic [15:0]         offset16_in;
  logic [REG_BITS-1:0] destReg_in;
  logic [3:0]          ALUCtrl_in;
  logic [11:0]         ctrl_in;
  logic [1:0]          DSize_in;
  logic [XLEN-1:0]     nextPC_out, aluResult_out, leapAddr_out;
  logic [REG_BITS-1:0] destReg_out;
  logic                leap_out, PCtoReg_out, RegWrite_out, MemToReg_out, MemWrite_out, loadSign_out;
  logic [1:0]          DSize_out;

  int   checks   = 0;
  int   failures = 0;
  out_t sb[$];

  execute_pipe_mc #(.XLEN(XLEN), .MUL_BPC(MUL_BPC), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .nextPC_in(nextPC_in), .opA_in(opA_in), .opB_in(opB_in),
    .offset26_in(offset26_in), .offset16_in(offset16_in), .destReg_in(destReg_in),
    .ALUCtrl_in(ALUCtrl_in), .ctrl_in(ctrl_in), .DSize_in(DSize_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .nextPC_out(nextPC_out), .aluResult_out(aluResult_out), .leapAddr_out(leapAddr_out),
    .destReg_out(destReg_out), .leap_out(leap_out), .PCtoReg_out(PCtoReg_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .MemWrite_out(MemWrite_out),
    .loadSign_out(loadSign_out), .DSize_out(DSize_out)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return {nextPC_out, aluResult_out, leapAddr_out, destReg_out, leap_out, PCtoReg_out,
            RegWrite_out, MemToReg_out, MemWrite_out, loadSign_out, DSize_out};
  endfunction

  function automatic out_t model(op_t op);
    out_t e;
    int   o16s, o26s;
    logic [4:0] sh;
    logic is_mul, is_jump, is_branch;
    sh        = op.b[4:0];
    is_mul    = |(op.ctrl & C_MUL);
    is_jump   = |(op.ctrl & C_JUMP);
    is_branch = |(op.ctrl & C_BRANCH);
    o16s      = signed'(op.o16);
    o26s      = signed'(op.o26);
    if (is_mul) e.res = op.a * op.b;
    else begin
      case (op.alu)
        OP_ADD:  e.res = op.a + op.b;
        OP_SUB:  e.res = op.a - op.b;
        OP_AND:  e.res = op.a & op.b;
        OP_OR:   e.res = op.a | op.b;
        OP_XOR:  e.res = op.a ^ op.b;
        OP_NOR:  e.res = ~(op.a | op.b);
        OP_SLT:  e.res = ($signed(op.a) < $signed(op.b)) ? 32'd1 : 32'd0;
        OP_SLTU: e.res = (op.a < op.b) ? 32'd1 : 32'd0;
        OP_SLL:  e.res = op.a << sh;
        OP_SRL:  e.res = op.a >> sh;
        OP_SRA:  e.res = $unsigned($signed(op.a) >>> sh);
        default: e.res = 32'd0;
      endcase
    end
    if (is_mul)         e.leap = 1'b0;
    else if (is_jump)   e.leap = 1'b1;
    else if (is_branch) e.leap = (op.ctrl & C_BZ) != 0 ? (op.a == 0) : (op.a != 0);
    else                e.leap = 1'b0;
    if ((op.ctrl & C_REGTOPC) != 0) e.laddr = op.a;
    else if (is_branch)             e.laddr = op.npc + o16s;
    else if (is_jump)               e.laddr = op.npc + o26s;
    else                            e.laddr = op.npc;
    e.npc      = op.npc;
    e.dest     = op.dest;
    e.pctoreg  = |(op.ctrl & C_PCTOREG);
    e.regwrite = |(op.ctrl & C_REGWRITE);
    e.memtoreg = |(op.ctrl & C_MEMTOREG);
    e.memwrite = |(op.ctrl & C_MEMWRITE);
    e.loadsign = |(op.ctrl & C_LOADSIGN);
    e.dsize    = op.dsize;
    return e;
  endfunction

  function automatic op_t mk(logic [3:0] alu, logic [31:0] a, logic [31:0] b, logic [31:0] npc,
                             logic [15:0] o16, logic [25:0] o26, logic [11:0] ctrl);
    op_t o;
    o.alu = alu; o.a = a; o.b = b; o.npc = npc; o.o16 = o16; o.o26 = o26; o.ctrl = ctrl;
    o.dest = 5'($urandom_range(1, 31));
    o.dsize = 2'($urandom_range(0, 3));
    return o;
  endfunction

  task automatic drive(input op_t op);
    ALUCtrl_in = op.alu; opA_in = op.a; opB_in = op.b; nextPC_in = op.npc;
    offset16_in = op.o16; offset26_in = op.o26; ctrl_in = op.ctrl;
    destReg_in = op.dest; DSize_in = op.dsize;
  endtask

  // Presents op and returns just after the edge that accepts it.
  task automatic issue(input op_t op, output bit ok);
    drive(op);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) sb.push_back(model(op));
    else begin
      checks++; failures++;
      $display("FAIL issue_timeout in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset();
    out_t z = '0;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(mk(OP_ADD, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    checks++;
    if (dut_out() !== z) begin
      failures++;
      $display("FAIL reset_data got %h required %h", dut_out(), z);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    bit ok;
    out_t e;
    out_ready = 1'b1;
    issue(mk(OP_ADD, 32'd5, 32'd7, 32'h104, 0, 0, C_RTYPE | C_REGWRITE), ok);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_latency out_valid=%b required 1", out_valid);
    end
    checks++;
    if (aluResult_out !== 32'd12) begin
      failures++;
      $display("FAIL add_result got %0d required 12", aluResult_out);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut_out() !== e) begin
        failures++;
        $display("FAIL add_bundle got %h required %h", dut_out(), e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_t e;
    op_t  op;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = mk(4'(i + (i / 4) * 3), $urandom, $urandom, $urandom & 32'hFFFFFFFC, 16'($urandom), 26'($urandom),
              C_REGWRITE | ((i % 2 == 1) ? C_MEMWRITE | C_LOADSIGN : C_PCTOREG | C_MEMTOREG));
      drive(op);
      in_valid = 1'b1;
      sb.push_back(model(op));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready op=%0d in_ready=%b required 1", i, in_ready);
      end
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || dut_out() !== e) begin
          failures++;
          $display("FAIL b2b_result op=%0d valid=%b got %h required %h", i - 1, out_valid, dut_out(), e);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || dut_out() !== e) begin
      failures++;
      $display("FAIL b2b_last valid=%b got %h required %h", out_valid, dut_out(), e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
    bit   ok, busy_err;
    int   n;
    out_t e;
    out_ready = 1'b1;
    issue(mk(OP_ADD, a, b, 32'h2000, 16'h0010, 26'h40, C_MUL | C_JUMP | C_REGWRITE), ok);
    n = 0; busy_err = 1'b0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 4 * MUL_CYC) begin
      if (in_ready !== 1'b0) busy_err = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != MUL_CYC) begin
      failures++;
      $display("FAIL mul_latency cycles=%0d required %0d", n, MUL_CYC);
    end
    checks++;
    if (busy_err) begin
      failures++;
      $display("FAIL mul_stall in_ready seen 1 while busy, required 0");
    end
    checks++;
    if (aluResult_out !== prod || leap_out !== 1'b0) begin
      failures++;
      $display("FAIL mul_result got %h leap=%b required %h leap=0", aluResult_out, leap_out, prod);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut_out() !== e) begin
        failures++;
        $display("FAIL mul_bundle got %h required %h", dut_out(), e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    op_t         tbl[5];
    logic        exp_leap[5];
    logic [31:0] exp_addr[5];
    bit          ok;
    out_t        e;
    tbl[0] = mk(OP_SUB, 32'd0, 32'd1, 32'h100, 16'hFFFC, 26'h0, C_BRANCH | C_BZ);
    exp_leap[0] = 1'b1; exp_addr[0] = 32'h000000FC;
    tbl[1] = mk(OP_SUB, 32'd3, 32'd1, 32'h100, 16'hFFFC, 26'h0, C_BRANCH | C_BZ);
    exp_leap[1] = 1'b0; exp_addr[1] = 32'h000000FC;
    tbl[2] = mk(OP_ADD, 32'h4000, 32'd0, 32'h300, 16'h0, 26'h0, C_REGTOPC | C_JUMP | C_PCTOREG);
    exp_leap[2] = 1'b1; exp_addr[2] = 32'h00004000;
    tbl[3] = mk(OP_ADD, 32'd0, 32'd0, 32'h1000, 16'h0, 26'h3FFFFF0, C_JUMP);
    exp_leap[3] = 1'b1; exp_addr[3] = 32'h00000FF0;
    tbl[4] = mk(OP_ADD, 32'd5, 32'd0, 32'hFFFFFFF0, 16'h0020, 26'h0, C_BRANCH);
    exp_leap[4] = 1'b1; exp_addr[4] = 32'h00000010;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i], ok);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || leap_out !== exp_leap[i] || leapAddr_out !== exp_addr[i]) begin
        failures++;
        $display("FAIL branch_%0d valid=%b leap=%b addr=%h required 1 %b %h",
                 i, out_valid, leap_out, leapAddr_out, exp_leap[i], exp_addr[i]);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (dut_out() !== e) begin
          failures++;
          $display("FAIL branch_bundle_%0d got %h required %h", i, dut_out(), e);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    out_t e;
    op_t  op_b;
    out_ready = 1'b0;
    issue(mk(OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 32'h44, 0, 0, C_REGWRITE), ok);
    op_b = mk(OP_OR, 32'h1200, 32'h0034, 32'h48, 0, 0, C_MEMWRITE);
    drive(op_b);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sb.size() == 0 || dut_out() !== sb[0]) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b got %h required held A32=a5a55a5a",
                 i, out_valid, in_ready, dut_out());
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready in_ready=%b required 1", in_ready);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    sb.push_back(model(op_b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || aluResult_out !== 32'h1234 || dut_out() !== e) begin
      failures++;
      $display("FAIL bp_next valid=%b got %h required %h", out_valid, dut_out(), e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    bit ok, seen;
    out_ready = 1'b1;
    issue(mk(OP_ADD, 32'd9, 32'd9, 32'h80, 0, 0, C_MUL | C_REGWRITE), ok);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_mul valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * MUL_CYC; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_no_result out_valid seen=1 required 0");
    end
    sb.delete();
    @(posedge clk); #1;
    drive(mk(OP_ADD, 32'd1, 32'd1, 0, 0, 0, 0));
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_accept out_valid=%b required 0", out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(mk(OP_ADD, 32'd2, 32'd2, 0, 0, 0, 0), ok);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_held out_valid=%b required 0", out_valid);
    end
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    bit   ok, seen;
    out_t z = '0;
    out_ready = 1'b1;
    issue(mk(OP_ADD, 32'd3, 32'd5, 32'hABC, 16'h1, 26'h1, C_MUL | C_REGWRITE | C_MEMTOREG), ok);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || dut_out() !== z) begin
      failures++;
      $display("FAIL reset_mul_outputs valid=%b got %h required 0", out_valid, dut_out());
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mul_ready in_ready=%b required 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * MUL_CYC; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mul_no_result out_valid seen=1 required 0");
    end
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; reset = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_mul(32'd6, 32'd7, 32'd42);
    test_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    test_mul(32'h0001_2345, 32'h0000_1001, 32'h0001_2345 * 32'h0000_1001);
    test_branch();
    test_backpressure();
    test_flush();
    test_add();
    test_reset_mid_mul();
    test_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
